// File: rtl/merlin_fifo_mp.sv
// -----------------------------------------------------------------------------
// merlin_fifo_mp
// Multi-port FIFO for the RV32IC fetch buffer. Up to C_WR_MAX entries are
// pushed and up to C_RD_MAX entries popped per cycle. The oldest C_RD_MAX
// entries are presented as a parallel read window with per-lane valids.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous reset, active-high
//   clk_en_i       clock enable; low holds all state (sticky flags included)
//   flush_i        synchronous discard of all contents
//   wr_cnt_i       number of entries to push this cycle
//   din_i          write lanes; lane 0 in LSBs, lane 0 is oldest
//   rd_cnt_i       number of entries to pop this cycle
//   dout_o         read window; lane k is the k-th oldest entry
//   valid_o        valid_o[k] = (level_o > k)
//   level_o        occupied entries
//   free_o         C_FIFO_DEPTH - level_o
//   empty_o        level_o == 0
//   full_o         level_o == C_FIFO_DEPTH
//   almost_full_o  free_o <= C_AF_THRESH
//   overflow_o     sticky: a push was rejected
//   underflow_o    sticky: a pop was rejected
//
// Transfer semantics: there is no valid/ready pair; the producer states how
// many entries it offers (wr_cnt_i) and the consumer how many it takes
// (rd_cnt_i). A request is accepted whole or not at all, judged only on the
// state before the edge: a push needs wr_cnt_i <= free_o, a pop needs
// rd_cnt_i <= level_o. A pop in the same cycle never makes room for a push,
// and a pushed entry becomes visible in the window one cycle after its edge.
// -----------------------------------------------------------------------------
module merlin_fifo_mp #(
  parameter int C_FIFO_WIDTH   = 16,
  parameter int C_FIFO_DEPTH_X = 3,
  parameter int C_WR_MAX       = 2,
  parameter int C_RD_MAX       = 2,
  parameter int C_AF_THRESH    = 2,
  localparam int C_FIFO_DEPTH  = 2**C_FIFO_DEPTH_X,
  localparam int C_CNT_W       = $clog2(((C_WR_MAX > C_RD_MAX) ? C_WR_MAX : C_RD_MAX) + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             clk_en_i,
  input  logic                             flush_i,
  input  logic [C_CNT_W-1:0]               wr_cnt_i,
  input  logic [C_WR_MAX*C_FIFO_WIDTH-1:0] din_i,
  input  logic [C_CNT_W-1:0]               rd_cnt_i,
  output logic [C_RD_MAX*C_FIFO_WIDTH-1:0] dout_o,
  output logic [C_RD_MAX-1:0]              valid_o,
  output logic [C_FIFO_DEPTH_X:0]          level_o,
  output logic [C_FIFO_DEPTH_X:0]          free_o,
  output logic                             empty_o,
  output logic                             full_o,
  output logic                             almost_full_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);

  localparam int PW = C_FIFO_DEPTH_X + 1;               // pointer width incl. wrap bit
  localparam int AW = C_FIFO_DEPTH_X;                   // memory index width
  localparam int CW = (C_CNT_W > PW) ? C_CNT_W : PW;    // common compare width

  logic [C_FIFO_WIDTH-1:0] mem [C_FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] level;
  logic [PW-1:0] free;
  logic [CW-1:0] wr_cnt_x;
  logic [CW-1:0] rd_cnt_x;
  logic          wr_ok;
  logic          rd_ok;
  logic          step;
  logic [AW-1:0] wr_idx [C_WR_MAX];
  logic [AW-1:0] rd_idx [C_RD_MAX];

  // Occupancy comes from the wrap-bit pointer difference, so full and empty
  // are distinguishable without a separate counter.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    free     = PW'(C_FIFO_DEPTH) - level;
    wr_cnt_x = CW'(wr_cnt_i);
    rd_cnt_x = CW'(rd_cnt_i);
    wr_ok    = (wr_cnt_x <= CW'(free));
    rd_ok    = (rd_cnt_x <= CW'(level));
    step     = clk_en_i && !flush_i;
  end

  // Lane indices wrap across the memory boundary via AW-bit truncation.
  always_comb begin
    for (int k = 0; k < C_WR_MAX; k++) begin
      wr_idx[k] = wr_ptr_q[AW-1:0] + AW'(k);
    end
    for (int k = 0; k < C_RD_MAX; k++) begin
      rd_idx[k] = rd_ptr_q[AW-1:0] + AW'(k);
    end
  end

  // Pointers and sticky flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        // Flush drops contents and any concurrent request; flags survive.
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr_q <= wr_ptr_q + PW'(wr_cnt_i);
        end else begin
          overflow_o <= 1'b1;
        end
        if (rd_ok) begin
          rd_ptr_q <= rd_ptr_q + PW'(rd_cnt_i);
        end else begin
          underflow_o <= 1'b1;
        end
      end
    end
  end

  // Storage has no reset. A rejected or flushed push writes nothing, so
  // stale data can never be exposed through the window.
  always_ff @(posedge clk_i) begin
    if (!reset_i && step && wr_ok) begin
      for (int k = 0; k < C_WR_MAX; k++) begin
        if (CW'(k) < wr_cnt_x) begin
          mem[wr_idx[k]] <= din_i[k*C_FIFO_WIDTH +: C_FIFO_WIDTH];
        end
      end
    end
  end

  // Read window and status, combinational from registered state only.
  always_comb begin
    for (int k = 0; k < C_RD_MAX; k++) begin
      dout_o[k*C_FIFO_WIDTH +: C_FIFO_WIDTH] = mem[rd_idx[k]];
      valid_o[k] = (level > PW'(k));
    end
    level_o       = level;
    free_o        = free;
    empty_o       = (level == '0);
    full_o        = (level == PW'(C_FIFO_DEPTH));
    almost_full_o = (int'(free) <= C_AF_THRESH);
  end

`ifdef RV_ASSERTS_ON
  a_push_rejected: assert property (@(posedge clk_i) disable iff (reset_i)
    step |-> wr_ok)
    else $error("merlin_fifo_mp: push rejected");

  a_pop_rejected: assert property (@(posedge clk_i) disable iff (reset_i)
    step |-> rd_ok)
    else $error("merlin_fifo_mp: pop rejected");

  a_cnt_range: assert property (@(posedge clk_i) disable iff (reset_i)
    clk_en_i |-> ((int'(wr_cnt_i) <= C_WR_MAX) && (int'(rd_cnt_i) <= C_RD_MAX)))
    else $error("merlin_fifo_mp: lane count above maximum");
`endif

endmodule
